decode_stage: RTL and testbench

- Instruction decode stage directly downstream of fetch.
- Contains the IF/ID pipeline register and classifies each instruction as normal, HALT, RTI or illegal.
- Generates fetch redirect pulses (illegal_op_idif_p1, return_execution_idif_p1) and squashes wrong-path instructions.
- Registers decoded fields into the ID/EX register for execute.

---
 rtl/decode_pkg.sv | 15 +
 rtl/decode_stage_classify.sv | 29 ++
 rtl/decode_stage.sv | 151 +++++++++++++++
 tb/tb_decode_stage.sv | 137 +++++++++++++
 4 files changed

// File: rtl/decode_pkg.sv
// decode_pkg: shared opcodes, legality mask, FSM state and fault cause types for the decode stage
package decode_pkg;
    localparam logic [4:0]  OPC_HALT = 5'b00000;
    localparam logic [4:0]  OPC_NOP  = 5'b00001;
    localparam logic [4:0]  OPC_SIIC = 5'b00010;
    localparam logic [4:0]  OPC_RTI  = 5'b00011;
    localparam logic [31:0] LEGAL_OPC_MASK_DEF = 32'hFFFF_FFFB;

    typedef enum logic [1:0] {RUN, SQUASH, HALTED} dec_state_t;
    typedef enum logic [1:0] {FAULT_NONE, FAULT_HALT, FAULT_FETCH, FAULT_DOUBLE} fault_t;

    function automatic logic [4:0] opcode(input logic [15:0] inst);
        return inst[15:11];
    endfunction
endpackage

// File: rtl/decode_stage_classify.sv
// inst_classify: combinational opcode classification and field extraction
module inst_classify
    import decode_pkg::*;
#(
    parameter logic [31:0] LEGAL_OPC_MASK = LEGAL_OPC_MASK_DEF
) (
    input  logic [15:0] inst,
    input  logic        in_handler,
    output logic        is_halt,
    output logic        is_rti_ok,
    output logic        is_illegal,
    output logic [2:0]  rs,
    output logic [2:0]  rt,
    output logic [2:0]  rd,
    output logic [15:0] imm
);
    logic [4:0] opc;
    logic       is_rti;

    assign opc        = opcode(inst);
    assign is_rti     = opc == OPC_RTI;
    assign is_halt    = opc == OPC_HALT;
    assign is_rti_ok  = is_rti && in_handler;
    assign is_illegal = (opc == OPC_SIIC) || !LEGAL_OPC_MASK[opc] || (is_rti && !in_handler);
    assign rs         = inst[10:8];
    assign rt         = inst[7:5];
    assign rd         = inst[4:2];
    assign imm        = {{11{inst[4]}}, inst[4:0]};
endmodule

// File: rtl/decode_stage.sv
// decode_stage: IF/ID register, exception/return redirect FSM and ID/EX register
module decode_stage
    import decode_pkg::*;
#(
    parameter logic [31:0] LEGAL_OPC_MASK = LEGAL_OPC_MASK_DEF
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] inst_ifid_p1,
    input  logic [15:0] pc_ifid_p1,
    input  logic        err_ifid_p1,
    input  logic        branch_taken_ixif_p1,
    output logic        illegal_op_idif_p1,
    output logic        return_execution_idif_p1,
    output logic        valid_idex_p1,
    output logic [15:0] inst_idex_p1,
    output logic [15:0] pc_idex_p1,
    output logic [2:0]  rs_idex_p1,
    output logic [2:0]  rt_idex_p1,
    output logic [2:0]  rd_idex_p1,
    output logic [15:0] imm_idex_p1,
    output logic        halt_p1,
    output logic [1:0]  fault_p1
);
    dec_state_t  state_q, state_d;
    fault_t      fault_q, fault_d;
    logic [15:0] ifid_inst_q, ifid_inst_d, ifid_pc_q, ifid_pc_d;
    logic        ifid_err_q, ifid_err_d, ifid_valid_q, ifid_valid_d;
    logic        in_handler_q, in_handler_d, halt_q, halt_d;
    logic        idex_valid_q, idex_valid_d;
    logic [15:0] idex_inst_q, idex_inst_d, idex_pc_q, idex_pc_d, idex_imm_q, idex_imm_d;
    logic [2:0]  idex_rs_q, idex_rs_d, idex_rt_q, idex_rt_d, idex_rd_q, idex_rd_d;
    logic        is_halt, is_rti_ok, is_illegal, live, issue, ill_p, ret_p;
    logic [2:0]  rs, rt, rd;
    logic [15:0] imm;

    inst_classify #(.LEGAL_OPC_MASK(LEGAL_OPC_MASK)) u_classify (
        .inst       (ifid_inst_q),
        .in_handler (in_handler_q),
        .is_halt    (is_halt),
        .is_rti_ok  (is_rti_ok),
        .is_illegal (is_illegal),
        .rs         (rs),
        .rt         (rt),
        .rd         (rd),
        .imm        (imm)
    );

    // Next-state, redirect pulses and issue decision in priority order
    always_comb begin
        state_d      = state_q;
        fault_d      = fault_q;
        in_handler_d = in_handler_q;
        issue        = 1'b0;
        ill_p        = 1'b0;
        ret_p        = 1'b0;
        live         = ifid_valid_q && (state_q == RUN);
        if (state_q == HALTED) begin
            state_d = HALTED;
        end else if (branch_taken_ixif_p1) begin
            state_d = SQUASH;
        end else if (!live) begin
            state_d = RUN;
        end else if (ifid_err_q) begin
            state_d = HALTED;
            fault_d = FAULT_FETCH;
        end else if (is_illegal && in_handler_q) begin
            state_d = HALTED;
            fault_d = FAULT_DOUBLE;
        end else if (is_illegal) begin
            ill_p        = 1'b1;
            in_handler_d = 1'b1;
            state_d      = SQUASH;
        end else if (is_rti_ok) begin
            ret_p        = 1'b1;
            in_handler_d = 1'b0;
            state_d      = SQUASH;
        end else if (is_halt) begin
            issue   = 1'b1;
            state_d = HALTED;
            fault_d = FAULT_HALT;
        end else begin
            issue = 1'b1;
        end
    end

    // Pipeline register inputs; ID/EX fields hold their value across bubbles
    always_comb begin
        halt_d       = state_d == HALTED;
        ifid_inst_d  = inst_ifid_p1;
        ifid_pc_d    = pc_ifid_p1;
        ifid_err_d   = err_ifid_p1;
        ifid_valid_d = state_d == RUN;
        idex_valid_d = issue;
        idex_inst_d  = issue ? ifid_inst_q : idex_inst_q;
        idex_pc_d    = issue ? ifid_pc_q   : idex_pc_q;
        idex_rs_d    = issue ? rs          : idex_rs_q;
        idex_rt_d    = issue ? rt          : idex_rt_q;
        idex_rd_d    = issue ? rd          : idex_rd_q;
        idex_imm_d   = issue ? imm         : idex_imm_q;
    end

    // State and pipeline registers, cleared asynchronously
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= RUN;
            fault_q      <= FAULT_NONE;
            halt_q       <= 1'b0;
            in_handler_q <= 1'b0;
            ifid_inst_q  <= '0;
            ifid_pc_q    <= '0;
            ifid_err_q   <= 1'b0;
            ifid_valid_q <= 1'b0;
            idex_valid_q <= 1'b0;
            idex_inst_q  <= '0;
            idex_pc_q    <= '0;
            idex_rs_q    <= '0;
            idex_rt_q    <= '0;
            idex_rd_q    <= '0;
            idex_imm_q   <= '0;
        end else begin
            state_q      <= state_d;
            fault_q      <= fault_d;
            halt_q       <= halt_d;
            in_handler_q <= in_handler_d;
            ifid_inst_q  <= ifid_inst_d;
            ifid_pc_q    <= ifid_pc_d;
            ifid_err_q   <= ifid_err_d;
            ifid_valid_q <= ifid_valid_d;
            idex_valid_q <= idex_valid_d;
            idex_inst_q  <= idex_inst_d;
            idex_pc_q    <= idex_pc_d;
            idex_rs_q    <= idex_rs_d;
            idex_rt_q    <= idex_rt_d;
            idex_rd_q    <= idex_rd_d;
            idex_imm_q   <= idex_imm_d;
        end
    end

    assign illegal_op_idif_p1       = ill_p;
    assign return_execution_idif_p1 = ret_p;
    assign valid_idex_p1            = idex_valid_q;
    assign inst_idex_p1             = idex_inst_q;
    assign pc_idex_p1               = idex_pc_q;
    assign rs_idex_p1               = idex_rs_q;
    assign rt_idex_p1               = idex_rt_q;
    assign rd_idex_p1               = idex_rd_q;
    assign imm_idex_p1              = idex_imm_q;
    assign halt_p1                  = halt_q;
    assign fault_p1                 = fault_q;
endmodule

// File: tb/tb_decode_stage.sv
// tb_decode_stage: directed cycle-by-cycle checks of decode, redirects, squash and halt
module tb_decode_stage;
    localparam logic [15:0] NOP  = 16'h0800;
    localparam logic [15:0] FNOP = 16'h0D7A;
    localparam logic [15:0] SIIC = 16'h1000;
    localparam logic [15:0] RTI  = 16'h1800;
    localparam logic [15:0] HALT = 16'h0000;
    localparam logic [15:0] BAD  = 16'hF800;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [15:0] inst_ifid_p1 = '0, pc_ifid_p1 = '0;
    logic        err_ifid_p1 = 1'b0, branch_taken_ixif_p1 = 1'b0;
    logic        illegal_op_idif_p1, return_execution_idif_p1, valid_idex_p1, halt_p1;
    logic [15:0] inst_idex_p1, pc_idex_p1, imm_idex_p1;
    logic [2:0]  rs_idex_p1, rt_idex_p1, rd_idex_p1;
    logic [1:0]  fault_p1;
    int          n_checks = 0, n_errors = 0;

    decode_stage #(.LEGAL_OPC_MASK(32'h7FFF_FFFB)) dut (
        .clk                      (clk),
        .rst                      (rst),
        .inst_ifid_p1             (inst_ifid_p1),
        .pc_ifid_p1               (pc_ifid_p1),
        .err_ifid_p1              (err_ifid_p1),
        .branch_taken_ixif_p1     (branch_taken_ixif_p1),
        .illegal_op_idif_p1       (illegal_op_idif_p1),
        .return_execution_idif_p1 (return_execution_idif_p1),
        .valid_idex_p1            (valid_idex_p1),
        .inst_idex_p1             (inst_idex_p1),
        .pc_idex_p1               (pc_idex_p1),
        .rs_idex_p1               (rs_idex_p1),
        .rt_idex_p1               (rt_idex_p1),
        .rd_idex_p1               (rd_idex_p1),
        .imm_idex_p1              (imm_idex_p1),
        .halt_p1                  (halt_p1),
        .fault_p1                 (fault_p1)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic cyc(input logic [15:0] i, input logic [15:0] p, input logic e, input logic b);
        @(posedge clk);
        #1;
        inst_ifid_p1         = i;
        pc_ifid_p1           = p;
        err_ifid_p1          = e;
        branch_taken_ixif_p1 = b;
        #1;
    endtask

    task automatic exp_io(input string tag, input logic v, input logic [15:0] pc, input logic ill, input logic ret);
        check({tag, ".valid"}, valid_idex_p1, v);
        check({tag, ".pc"}, pc_idex_p1, pc);
        check({tag, ".ill"}, illegal_op_idif_p1, ill);
        check({tag, ".ret"}, return_execution_idif_p1, ret);
    endtask

    task automatic exp_halt(input string tag, input logic h, input logic [1:0] f);
        check({tag, ".halt"}, halt_p1, h);
        check({tag, ".fault"}, fault_p1, f);
    endtask

    task automatic exp_fields(input string tag, input logic [15:0] inst);
        check({tag, ".inst"}, inst_idex_p1, inst);
        check({tag, ".rs"}, rs_idex_p1, 3'd5);
        check({tag, ".rt"}, rt_idex_p1, 3'd3);
        check({tag, ".rd"}, rd_idex_p1, 3'd6);
        check({tag, ".imm"}, imm_idex_p1, 16'hFFFA);
    endtask

    initial begin
        cyc(NOP, 16'h0000, 1'b0, 1'b0);
        exp_io("a0", 1'b0, 16'h0000, 1'b0, 1'b0);
        exp_halt("a0", 1'b0, 2'd0);
        check("a0.inst", inst_idex_p1, 16'h0000);
        rst = 1'b0;
        cyc(FNOP, 16'h0002, 1'b0, 1'b0);  exp_io("a1", 1'b0, 16'h0000, 1'b0, 1'b0);
        cyc(SIIC, 16'h0004, 1'b0, 1'b0);  exp_io("a2", 1'b1, 16'h0000, 1'b0, 1'b0);
        cyc(NOP,  16'h0006, 1'b0, 1'b0);  exp_io("a3", 1'b1, 16'h0002, 1'b1, 1'b0);
        exp_fields("a3", FNOP);
        cyc(FNOP, 16'h0002, 1'b0, 1'b0);  exp_io("a4", 1'b0, 16'h0002, 1'b0, 1'b0);
        cyc(RTI,  16'h0004, 1'b0, 1'b0);  exp_io("a5", 1'b0, 16'h0002, 1'b0, 1'b0);
        cyc(NOP,  16'h0006, 1'b0, 1'b0);  exp_io("a6", 1'b1, 16'h0002, 1'b0, 1'b1);
        cyc(NOP,  16'h0020, 1'b0, 1'b0);  exp_io("a7", 1'b0, 16'h0002, 1'b0, 1'b0);
        cyc(RTI,  16'h0022, 1'b0, 1'b0);  exp_io("a8", 1'b0, 16'h0002, 1'b0, 1'b0);
        cyc(NOP,  16'h0024, 1'b0, 1'b0);  exp_io("a9", 1'b1, 16'h0020, 1'b1, 1'b0);
        cyc(SIIC, 16'h0002, 1'b0, 1'b0);  exp_io("a10", 1'b0, 16'h0020, 1'b0, 1'b0);
        cyc(NOP,  16'h0004, 1'b0, 1'b0);  exp_io("a11", 1'b0, 16'h0020, 1'b0, 1'b0);
        exp_halt("a11", 1'b0, 2'd0);
        for (int k = 0; k < 3; k++) begin
            cyc(NOP, 16'h0006, 1'b0, 1'b0);
            exp_io("a12", 1'b0, 16'h0020, 1'b0, 1'b0);
            exp_halt("a12", 1'b1, 2'd3);
        end
        rst = 1'b1;
        cyc(NOP, 16'h0040, 1'b0, 1'b0);
        exp_io("b0", 1'b0, 16'h0000, 1'b0, 1'b0);
        exp_halt("b0", 1'b0, 2'd0);
        rst = 1'b0;
        cyc(BAD,  16'h0042, 1'b0, 1'b0);  exp_io("b1", 1'b0, 16'h0000, 1'b0, 1'b0);
        cyc(NOP,  16'h0044, 1'b0, 1'b1);  exp_io("b2", 1'b1, 16'h0040, 1'b0, 1'b0);
        cyc(FNOP, 16'h0080, 1'b0, 1'b0);  exp_io("b3", 1'b0, 16'h0040, 1'b0, 1'b0);
        cyc(NOP,  16'h0082, 1'b0, 1'b0);  exp_io("b4", 1'b0, 16'h0040, 1'b0, 1'b0);
        cyc(HALT, 16'h0008, 1'b0, 1'b0);  exp_io("b5", 1'b1, 16'h0080, 1'b0, 1'b0);
        exp_fields("b5", FNOP);
        cyc(NOP,  16'h000A, 1'b0, 1'b0);  exp_io("b6", 1'b1, 16'h0082, 1'b0, 1'b0);
        exp_halt("b6", 1'b0, 2'd0);
        cyc(NOP,  16'h000C, 1'b0, 1'b0);  exp_io("b7", 1'b1, 16'h0008, 1'b0, 1'b0);
        exp_halt("b7", 1'b1, 2'd1);
        check("b7.inst", inst_idex_p1, HALT);
        cyc(NOP,  16'h000E, 1'b0, 1'b0);  exp_io("b8", 1'b0, 16'h0008, 1'b0, 1'b0);
        exp_halt("b8", 1'b1, 2'd1);
        #2;
        rst = 1'b1;
        #1;
        exp_io("rst", 1'b0, 16'h0000, 1'b0, 1'b0);
        exp_halt("rst", 1'b0, 2'd0);
        cyc(NOP, 16'h0000, 1'b0, 1'b0);
        rst = 1'b0;
        cyc(NOP, 16'h0002, 1'b1, 1'b0);  exp_io("c1", 1'b0, 16'h0000, 1'b0, 1'b0);
        cyc(NOP, 16'h0004, 1'b0, 1'b0);  exp_io("c2", 1'b1, 16'h0000, 1'b0, 1'b0);
        exp_halt("c2", 1'b0, 2'd0);
        cyc(NOP, 16'h0006, 1'b0, 1'b0);  exp_io("c3", 1'b0, 16'h0000, 1'b0, 1'b0);
        exp_halt("c3", 1'b1, 2'd2);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
